// File: rtl/adau1761_config_sequencer.sv
// ADAU1761 configuration sequencer: runs the 9-bit program held in the config ROM
// and turns it into START/byte/STOP commands, delays, jumps and trigger-driven branches.
module adau1761_config_sequencer #(
    parameter int DELAY_CYCLES = 400000,
    parameter int DELAY_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] rom_address,
    input  logic [8:0] rom_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_type,
    output logic [7:0] cmd_data,
    input  logic       cmd_done,
    input  logic       cmd_nack,
    input  logic [1:0] trig,
    output logic [1:0] trig_ack,
    output logic       config_done,
    output logic       nack_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE,
        S_DELAY
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [9:0]         r_pc;
    logic               r_in_txn;
    logic               r_skip;
    logic [DELAY_W-1:0] r_dly_cnt;
    logic [1:0]         r_cmd_type;
    logic [7:0]         r_cmd_data;
    logic               r_config_done;
    logic               r_nack_error;

    logic       w_is_write;
    logic       w_is_stop;
    logic       w_is_delay;
    logic       w_is_jump;
    logic       w_is_test;
    logic       w_test_bit;
    logic       w_issue_stop;
    logic       w_dly_last;
    logic [9:0] w_jump_target;

    assign w_is_write    = rom_data[8];
    assign w_is_stop     = (rom_data == 9'h0FF);
    assign w_is_delay    = (rom_data == 9'h0EF);
    assign w_is_jump     = (rom_data[8:5] == 4'b0000);
    assign w_is_test     = (rom_data[8:1] == 8'b0100_0000);
    assign w_test_bit    = trig[rom_data[0]];
    // A STOP only reaches the bus when a transaction is actually open.
    assign w_issue_stop  = w_is_stop & r_in_txn;
    assign w_dly_last    = (r_dly_cnt == DELAY_W'(DELAY_CYCLES - 1));
    assign w_jump_target = {2'b00, rom_data[4:0], 3'b000};

    assign rom_address = r_pc;
    assign cmd_type    = r_cmd_type;
    assign cmd_data    = r_cmd_data;
    assign config_done = r_config_done;
    assign nack_error  = r_nack_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH1;
            r_pc          <= '0;
            r_in_txn      <= 1'b0;
            r_skip        <= 1'b0;
            r_dly_cnt     <= '0;
            r_cmd_type    <= 2'b00;
            r_cmd_data    <= '0;
            r_config_done <= 1'b0;
            r_nack_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_DECODE: begin
                    if (w_is_write) begin
                        r_cmd_type <= r_in_txn ? 2'b01 : 2'b00;
                        r_cmd_data <= rom_data[7:0];
                        r_in_txn   <= 1'b1;
                    end else if (w_issue_stop) begin
                        r_cmd_type <= 2'b10;
                        r_cmd_data <= rom_data[7:0];
                        r_in_txn   <= 1'b0;
                    end else if (w_is_delay) begin
                        r_dly_cnt <= '0;
                    end else if (w_is_jump) begin
                        r_pc   <= r_skip ? r_pc + 10'd1 : w_jump_target;
                        r_skip <= 1'b0;
                    end else begin
                        if (w_is_test) begin
                            r_skip        <= ~w_test_bit;
                            r_config_done <= 1'b1;
                        end
                        r_pc <= r_pc + 10'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (cmd_done) begin
                        r_pc <= r_pc + 10'd1;
                        if (cmd_nack) r_nack_error <= 1'b1;
                    end
                end
                S_DELAY: begin
                    r_dly_cnt <= r_dly_cnt + DELAY_W'(1);
                    if (w_dly_last) r_pc <= r_pc + 10'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH1:    w_next = S_FETCH2;
            S_FETCH2:    w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_write || w_issue_stop) w_next = S_ISSUE;
                else if (w_is_delay)            w_next = S_DELAY;
                else                            w_next = S_FETCH1;
            end
            S_ISSUE:     if (cmd_ready)  w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (cmd_done)   w_next = S_FETCH1;
            S_DELAY:     if (w_dly_last) w_next = S_FETCH1;
            default:     w_next = S_FETCH1;
        endcase
    end

    always_comb begin
        cmd_valid = (r_state == S_ISSUE);
        busy      = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE) || (r_state == S_DELAY);
        trig_ack  = 2'b00;
        if ((r_state == S_DECODE) && w_is_test && w_test_bit) trig_ack[rom_data[0]] = 1'b1;
    end

endmodule

// File: tb/tb_adau1761_config_sequencer.sv
// Bench for adau1761_config_sequencer: ROM + I2C engine models, and an instruction-level
// reference interpreter that predicts the command stream, trigger acks and status flags.
module tb_adau1761_config_sequencer;

    localparam int DLY = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] rom_address;
    logic [8:0] rom_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       cmd_done;
    logic       cmd_nack;
    logic [1:0] trig;
    logic [1:0] trig_ack;
    logic       config_done;
    logic       nack_error;
    logic       busy;

    adau1761_config_sequencer #(.DELAY_CYCLES(DLY), .DELAY_W(20)) dut (
        .clk(clk), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_data(cmd_data),
        .cmd_done(cmd_done), .cmd_nack(cmd_nack), .trig(trig), .trig_ack(trig_ack),
        .config_done(config_done), .nack_error(nack_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Two-stage registered ROM: data valid two clocks after the address changes.
    logic [8:0] mem [0:1023];
    logic [8:0] rom_q1;
    always @(posedge clk) begin
        rom_q1   <= mem[rom_address];
        rom_data <= rom_q1;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Engine knobs and observations
    int         rl_fix, dl_fix, nack_idx;
    bit         nack_rand, spur_en;
    int         e_ph, e_cnt;
    bit         e_nack;
    bit         obs_nack;
    logic [9:0] obs_q[$];
    int         ack0, ack1;

    // Reference model results
    logic [9:0] exp_q[$];
    int         exp_ack0, exp_ack1;
    bit         exp_cfg;

    task automatic tick();
        @(negedge clk);
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        cmd_nack  = 1'b0;
        if (reset) begin
            e_ph = 0;
        end else begin
            if (e_ph == 0 && cmd_valid) begin
                e_cnt = (rl_fix >= 0) ? rl_fix : $urandom_range(0, 5);
                e_ph  = 1;
            end else if (e_ph == 0 && spur_en && $urandom_range(0, 19) == 0) begin
                cmd_done = 1'b1;
                cmd_nack = 1'b1;
            end
            if (e_ph == 1) begin
                if (e_cnt == 0) begin
                    cmd_ready = 1'b1;
                    obs_q.push_back({cmd_type, cmd_data});
                    e_nack = (int'(obs_q.size()) - 1 == nack_idx) || (nack_rand && $urandom_range(0, 7) == 0);
                    e_cnt  = (dl_fix >= 0) ? dl_fix : $urandom_range(1, 10);
                    e_ph   = 2;
                end else e_cnt--;
            end else if (e_ph == 2) begin
                if (e_cnt == 0) begin
                    cmd_done = 1'b1;
                    cmd_nack = e_nack;
                    if (e_nack) obs_nack = 1'b1;
                    e_ph = 0;
                end else e_cnt--;
            end
        end
        if (trig_ack[0]) ack0++;
        if (trig_ack[1]) ack1++;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 1024; a++) mem[a] = 9'h020;
    endtask

    task automatic set_halt(input int h);
        mem[h]     = 9'(h / 8);
        mem[h + 1] = 9'(h / 8);
    endtask

    // Instruction-level interpreter with trig held constant.
    task automatic model_run(input logic [1:0] tg, input int halt);
        int pc = 0;
        bit in_txn = 0;
        bit skip = 0;
        logic [8:0] w;
        exp_q.delete();
        exp_ack0 = 0;
        exp_ack1 = 0;
        exp_cfg  = 0;
        for (int s = 0; s < 5000 && pc != halt; s++) begin
            w = mem[pc];
            if (w[8]) begin
                exp_q.push_back({in_txn ? 2'b01 : 2'b00, w[7:0]});
                in_txn = 1;
                pc++;
            end else if (w[7:0] == 8'hFF) begin
                if (in_txn) exp_q.push_back({2'b10, 8'h00});
                in_txn = 0;
                pc++;
            end else if (w[7:5] == 3'b000) begin
                pc   = skip ? pc + 1 : int'(w[4:0]) * 8;
                skip = 0;
            end else if (w[7:1] == 7'b1000000) begin
                if (tg[w[0]]) begin
                    if (w[0]) exp_ack1++;
                    else exp_ack0++;
                end
                skip    = !tg[w[0]];
                exp_cfg = 1;
                pc++;
            end else begin
                pc++;
            end
            pc = pc % 1024;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_prog(input string name, input logic [1:0] tg, input int halt, input int budget);
        bit hit = 0;
        int n;
        model_run(tg, halt);
        trig = tg;
        do_reset();
        obs_q.delete();
        ack0 = 0;
        ack1 = 0;
        obs_nack = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if ((int'(rom_address) == halt || int'(rom_address) == halt + 1) && !busy &&
                obs_q.size() == exp_q.size()) begin
                hit = 1;
                break;
            end
        end
        for (int c = 0; c < 6; c++) tick();
        check_eq({name, ".halt_reached"}, 32'(hit), 32'd1);
        check_eq({name, ".cmd_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s.type[%0d]", name, i), 32'(obs_q[i][9:8]), 32'(exp_q[i][9:8]));
            if (exp_q[i][9:8] != 2'b10)
                check_eq($sformatf("%s.data[%0d]", name, i), 32'(obs_q[i][7:0]), 32'(exp_q[i][7:0]));
        end
        check_eq({name, ".ack0"}, ack0, exp_ack0);
        check_eq({name, ".ack1"}, ack1, exp_ack1);
        check_eq({name, ".config_done"}, 32'(config_done), 32'(exp_cfg));
        check_eq({name, ".nack_error"}, 32'(nack_error), 32'(obs_nack));
    endtask

    task automatic gen_random(input int halt);
        clear_mem();
        for (int a = 0; a < halt; a++) begin
            int r = $urandom_range(0, 99);
            int jlo = a / 8 + 1;
            if (r < 40)      mem[a] = {1'b1, 8'($urandom)};
            else if (r < 52) mem[a] = 9'h0FF;
            else if (r < 54) mem[a] = 9'h0EF;
            else if (r < 66) mem[a] = 9'h080 | 9'($urandom_range(0, 1));
            else if (r < 76 && jlo <= halt / 8) mem[a] = 9'($urandom_range(jlo, halt / 8));
            else             mem[a] = 9'h020 | 9'($urandom_range(0, 31));
        end
        set_halt(halt);
    endtask

    task automatic load_prog_a();
        clear_mem();
        mem[0] = 9'h0FF;
        mem[1] = 9'h176;
        mem[2] = 9'h140;
        mem[3] = 9'h100;
        mem[4] = 9'h10E;
        mem[5] = 9'h0FF;
        mem[6] = 9'h0FF;
        mem[7] = 9'h155;
        mem[8] = 9'h0FF;
        set_halt(16);
    endtask

    initial begin
        bit hit;
        int n, lo, hi;
        bit vseen;
        logic [9:0] a_last;

        reset = 1'b1; trig = 2'b00;
        cmd_ready = 1'b0; cmd_done = 1'b0; cmd_nack = 1'b0;
        rl_fix = 3; dl_fix = 20; nack_idx = -1; nack_rand = 0; spur_en = 0;
        e_ph = 0; e_cnt = 0; e_nack = 0; obs_nack = 0; ack0 = 0; ack1 = 0;
        clear_mem();
        for (int i = 0; i < 3; i++) tick();
        check_eq("rst.rom_address", 32'(rom_address), 32'd0);
        check_eq("rst.cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst.cmd_type", 32'(cmd_type), 32'd0);
        check_eq("rst.cmd_data", 32'(cmd_data), 32'd0);
        check_eq("rst.trig_ack", 32'(trig_ack), 32'd0);
        check_eq("rst.flags", {29'd0, config_done, nack_error, busy}, 32'd0);

        load_prog_a();
        run_prog("progA", 2'b00, 16, 2000);

        nack_idx = 1;
        run_prog("nack2", 2'b00, 16, 2000);
        nack_idx = -1;

        // DELAY timing
        clear_mem();
        mem[0] = 9'h0EF;
        set_halt(8);
        do_reset();
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            hit = busy;
        end
        check_eq("delay.start", 32'(hit), 32'd1);
        n = 0; vseen = 0; a_last = rom_address;
        while (busy && n < 200) begin
            a_last = rom_address;
            if (cmd_valid) vseen = 1;
            n++;
            tick();
        end
        check_eq("delay.cycles", n, DLY);
        check_eq("delay.addr_during", 32'(a_last), 32'd0);
        check_eq("delay.addr_after", 32'(rom_address), 32'd1);
        check_eq("delay.no_valid", 32'(vseen), 32'd0);

        // Trigger polling loop at 152
        clear_mem();
        mem[0] = 9'h013;
        mem[152] = 9'h080; mem[153] = 9'h014; mem[154] = 9'h081;
        mem[155] = 9'h019; mem[156] = 9'h013;
        set_halt(160);
        set_halt(200);
        trig = 2'b00;
        do_reset();
        ack0 = 0; ack1 = 0;
        for (int c = 0; c < 20; c++) tick();
        lo = 1023; hi = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (int'(rom_address) < lo) lo = int'(rom_address);
            if (int'(rom_address) > hi) hi = int'(rom_address);
        end
        check_eq("poll.min_pc", lo, 152);
        check_eq("poll.max_pc", hi, 156);
        check_eq("poll.acks", ack0 + ack1, 0);
        check_eq("poll.config_done", 32'(config_done), 32'd1);
        run_prog("poll_t01", 2'b01, 160, 500);
        run_prog("poll_t10", 2'b10, 200, 500);

        // Reset while a command is outstanding
        clear_mem();
        mem[0] = 9'h080; mem[1] = 9'h111; mem[2] = 9'h122; mem[3] = 9'h0FF;
        set_halt(8);
        trig = 2'b01; rl_fix = 1; dl_fix = 20; nack_idx = 0;
        do_reset();
        obs_q.delete();
        for (int c = 0; c < 300 && obs_q.size() < 2; c++) tick();
        for (int c = 0; c < 5; c++) tick();
        check_eq("rstmid.pre_busy", {30'd0, busy, cmd_valid}, 32'd2);
        check_eq("rstmid.pre_flags", {30'd0, config_done, nack_error}, 32'd3);
        reset = 1'b1;
        tick();
        check_eq("rstmid.rom_address", 32'(rom_address), 32'd0);
        check_eq("rstmid.cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("rstmid.flags", {29'd0, config_done, nack_error, busy}, 32'd0);
        tick();
        reset = 1'b0;
        obs_q.delete();
        nack_idx = -1;
        for (int c = 0; c < 300 && obs_q.size() < 1; c++) tick();
        check_eq("rstmid.first_cmd", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFF, {22'd0, 2'b00, 8'h11});

        // Random programs with random engine timing, NACKs and stray done pulses
        rl_fix = -1; dl_fix = -1; nack_rand = 1; spur_en = 1;
        for (int k = 0; k < 4; k++) begin
            gen_random(240);
            run_prog($sformatf("rand%0d", k), 2'($urandom_range(0, 3)), 240, 30000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
